// File: rtl/prach_mixer_ctrl.sv
// FCW scheduler for the PRACH mixer: software fills a shadow table, and the whole
// table is copied to the active table in one edge on the sync_in that follows an armed commit.
module prach_mixer_ctrl #(
   parameter int N_ANT = 3,
   parameter int N_CHN = 8,
   parameter int FCW_W = 16
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  wr_valid,
   output logic                                  wr_ready,
   input  logic [4:0]                            wr_addr,
   input  logic [FCW_W-1:0]                      wr_data,
   input  logic                                  commit_req,
   input  logic                                  commit_abort,
   input  logic                                  sync_in,
   output logic [N_ANT-1:0][N_CHN-1:0][FCW_W-1:0] ctrl_fcw,
   output logic                                  fcw_update,
   output logic                                  commit_busy,
   output logic [7:0]                            commit_cnt,
   output logic                                  err_addr,
   input  logic                                  err_clr
);

   // state  | meaning
   // IDLE   | writes accepted, waiting for commit_req
   // ARMED  | writes blocked, waiting for sync_in (or abort)
   // UPDATE | first cycle the new active table is visible
   typedef enum logic [1:0] {IDLE, ARMED, UPDATE} state_t;

   state_t state, state_nxt;
   logic   do_commit;

   logic [N_ANT-1:0][N_CHN-1:0][FCW_W-1:0] shadow;
   logic [N_ANT-1:0][N_CHN-1:0][FCW_W-1:0] active;

   logic [1:0] wr_ant;
   logic [2:0] wr_chn;
   logic       wr_fire;
   logic       ant_ok;

   assign wr_ant  = wr_addr[4:3];
   assign wr_chn  = wr_addr[2:0];
   assign wr_fire = wr_valid && wr_ready;
   assign ant_ok  = ({30'd0, wr_ant} < N_ANT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      do_commit   = 1'b0;
      wr_ready    = 1'b0;
      commit_busy = 1'b1;
      fcw_update  = 1'b0;
      case (state)
         IDLE: begin
            wr_ready    = 1'b1;
            commit_busy = 1'b0;
            if (commit_req) state_nxt = ARMED;
         end
         ARMED: begin
            // abort wins over a coincident sync so a cancelled commit never lands
            if (commit_abort) begin
               state_nxt = IDLE;
            end else if (sync_in) begin
               state_nxt = UPDATE;
               do_commit = 1'b1;
            end
         end
         UPDATE: begin
            fcw_update = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow <= '0;
      end else if (wr_fire && ant_ok) begin
         shadow[wr_ant][wr_chn] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active     <= '0;
         commit_cnt <= 8'd0;
      end else if (do_commit) begin
         active     <= shadow;
         commit_cnt <= commit_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                       err_addr <= 1'b0;
      else if (wr_fire && !ant_ok)   err_addr <= 1'b1;
      else if (err_clr)              err_addr <= 1'b0;
   end

   assign ctrl_fcw = active;

endmodule

// File: tb/tb_prach_mixer_ctrl.sv
// Bench for prach_mixer_ctrl: cycle model plus a scoreboard of expected active tables
// pushed when a commit is driven and popped when fcw_update is seen.
module tb_prach_mixer_ctrl;

   typedef struct packed {
      logic [2:0][7:0][15:0] tbl;
      logic [7:0]            cnt;
   } exp_t;

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic                  wr_valid = 1'b0;
   logic                  wr_ready;
   logic [4:0]            wr_addr = '0;
   logic [15:0]           wr_data = '0;
   logic                  commit_req = 1'b0;
   logic                  commit_abort = 1'b0;
   logic                  sync_in = 1'b0;
   logic [2:0][7:0][15:0] ctrl_fcw;
   logic                  fcw_update;
   logic                  commit_busy;
   logic [7:0]            commit_cnt;
   logic                  err_addr;
   logic                  err_clr = 1'b0;

   prach_mixer_ctrl #(.N_ANT(3), .N_CHN(8), .FCW_W(16)) dut (
      .clk(clk), .rst(rst),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .commit_req(commit_req), .commit_abort(commit_abort), .sync_in(sync_in),
      .ctrl_fcw(ctrl_fcw), .fcw_update(fcw_update), .commit_busy(commit_busy),
      .commit_cnt(commit_cnt), .err_addr(err_addr), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   exp_t sb_q[$];

   logic [2:0][7:0][15:0] m_sh, m_act;
   logic [1:0]            m_state;
   logic [7:0]            m_cnt;
   logic                  m_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_sh = '0; m_act = '0; m_state = 2'd0; m_cnt = 8'd0; m_err = 1'b0;
      sb_q.delete();
   endtask

   task automatic model_edge();
      exp_t       e;
      logic [1:0] a;
      logic       set_err;
      a = wr_addr[4:3];
      set_err = (m_state == 2'd0) && wr_valid && (a == 2'd3);
      if (m_state == 2'd0 && wr_valid && a != 2'd3) m_sh[a][wr_addr[2:0]] = wr_data;
      if (set_err) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      case (m_state)
         2'd0: if (commit_req) m_state = 2'd1;
         2'd1: begin
            if (commit_abort) m_state = 2'd0;
            else if (sync_in) begin
               m_act = m_sh;
               m_cnt = m_cnt + 8'd1;
               e.tbl = m_sh;
               e.cnt = m_cnt;
               sb_q.push_back(e);
               m_state = 2'd2;
            end
         end
         default: m_state = 2'd0;
      endcase
   endtask

   // drive one cycle of inputs at a negedge, model the edge, check at the next negedge
   task automatic step(input logic wv, input logic [4:0] wa, input logic [15:0] wd,
                       input logic cr, input logic ca, input logic sy, input logic ec);
      exp_t e;
      wr_valid = wv; wr_addr = wa; wr_data = wd;
      commit_req = cr; commit_abort = ca; sync_in = sy; err_clr = ec;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("wr_ready", wr_ready, m_state == 2'd0);
      chk("commit_busy", commit_busy, m_state != 2'd0);
      chk("fcw_update", fcw_update, m_state == 2'd2);
      chk("commit_cnt", commit_cnt, m_cnt);
      chk("err_addr", err_addr, m_err);
      chk("active_tbl_eq", ctrl_fcw === m_act, 1);
      if (fcw_update) begin
         chk("sb_pending", sb_q.size(), 1);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_cnt", commit_cnt, e.cnt);
            for (int a = 0; a < 3; a++)
               for (int c = 0; c < 8; c++)
                  chk($sformatf("sb_fcw[%0d][%0d]", a, c), ctrl_fcw[a][c], e.tbl[a][c]);
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 5'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_fcw_zero"}, ctrl_fcw == '0, 1);
      chk({tag, "_ready"}, wr_ready, 1);
      chk({tag, "_cnt"}, commit_cnt, 0);
      chk({tag, "_busy"}, commit_busy, 0);
      chk({tag, "_upd"}, fcw_update, 0);
      chk({tag, "_err"}, err_addr, 0);
   endtask

   initial begin
      model_reset();
      #1 rst = 1'b1;
      #1 reset_checks("rst0");
      @(negedge clk);
      rst = 1'b0;

      // write without commit stays in the shadow table
      step(1'b1, 5'b01_101, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(3);
      chk("nocommit_fcw15", ctrl_fcw[1][5], 16'h0000);

      // basic commit, sync 10 cycles after commit_req
      step(1'b0, 5'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("armed_ready_low", wr_ready, 0);
      idle(9);
      chk("armed_ready_still_low", wr_ready, 0);
      step(1'b0, 5'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("basic_fcw15", ctrl_fcw[1][5], 16'h1234);
      chk("basic_upd", fcw_update, 1);
      chk("basic_cnt", commit_cnt, 1);
      chk("basic_ready_upd", wr_ready, 0);
      idle(1);
      chk("basic_upd_once", fcw_update, 0);
      chk("basic_ready_back", wr_ready, 1);

      // commit_req + sync_in + write in the same IDLE cycle
      step(1'b1, 5'b10_111, 16'hBEEF, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("coinc_no_upd", fcw_update, 0);
      chk("coinc_fcw27_old", ctrl_fcw[2][7], 16'h0000);
      idle(3);
      step(1'b0, 5'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("coinc_fcw27_new", ctrl_fcw[2][7], 16'hBEEF);
      chk("coinc_cnt", commit_cnt, 2);
      idle(1);

      // abort together with sync
      step(1'b1, 5'b00_000, 16'h5555, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(2);
      step(1'b0, 5'd0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("abort_busy", commit_busy, 0);
      chk("abort_ready", wr_ready, 1);
      chk("abort_fcw00", ctrl_fcw[0][0], 16'h0000);
      chk("abort_cnt", commit_cnt, 2);
      step(1'b0, 5'd0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("idle_sync_ignored", fcw_update, 0);

      // error flag
      step(1'b1, 5'b11_010, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("err_set", err_addr, 1);
      step(1'b1, 5'b11_000, 16'hCAFE, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("err_set_wins", err_addr, 1);
      step(1'b0, 5'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("err_cleared", err_addr, 0);
      // commit shows the ant=3 writes did not alias into the table
      step(1'b0, 5'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 5'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("err_commit_fcw02", ctrl_fcw[0][2], 16'h0000);
      chk("err_commit_fcw00", ctrl_fcw[0][0], 16'h5555);
      idle(1);

      // reset while armed
      step(1'b0, 5'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1 reset_checks("rst_armed");
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      idle(1);

      // counter wrap; UPDATE cycle carries sync/req/abort/write that must be ignored
      for (int i = 0; i < 256; i++) begin
         step(1'b1, {2'($urandom_range(0, 2)), 3'($urandom_range(0, 7))},
              16'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
         step(1'b0, 5'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
         step(1'b1, {2'($urandom_range(0, 2)), 3'($urandom_range(0, 7))},
              16'($urandom), 1'b1, 1'b1, 1'b1, 1'b0);
         if (i == 254) chk("cnt_255", commit_cnt, 8'd255);
      end
      chk("cnt_wrap", commit_cnt, 8'd0);
      chk("no_double_upd", fcw_update, 0);
      idle(2);
      chk("sb_drained", sb_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
